// File: rtl/mont_modexp_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mont_modexp_ctrl
// Description : Left-to-right square-and-multiply controller for modular
//               exponentiation y = a^e mod m. The Montgomery products are
//               computed by one shared external multiplier.
//               Sequence: TO_MONT, then for every exponent bit from MSB down
//               a SQR, followed by a MUL when the bit is set, then FROM_MONT.
// Ports       : clk, rst_n             clock, synchronous active-low reset
//               start_p_i              one-cycle start request (IDLE only)
//               a_i, m_i, r_red_i, r2_red_i, m_inv_i, e_i   operands
//               mm_a_o, mm_b_o, mm_m_o, mm_m_inv_o          multiplier operands
//               mm_enable_p_o          one-cycle multiplier launch
//               mm_y_i, mm_done_p_i    multiplier result / completion pulse
//               y_o, busy_o, done_irq_p_o                   result and status
// Revision    : 1.0 - initial release
// ============================================================================
module mont_modexp_ctrl #(
    parameter int NBITS = 2048,
    parameter int EBITS = 2048
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_p_i,
    input  logic [NBITS-1:0] a_i,
    input  logic [NBITS-1:0] m_i,
    input  logic [NBITS-1:0] r_red_i,
    input  logic [NBITS-1:0] r2_red_i,
    input  logic [NBITS-1:0] m_inv_i,
    input  logic [EBITS-1:0] e_i,
    output logic [NBITS-1:0] mm_a_o,
    output logic [NBITS-1:0] mm_b_o,
    output logic [NBITS-1:0] mm_m_o,
    output logic [NBITS-1:0] mm_m_inv_o,
    output logic             mm_enable_p_o,
    input  logic [NBITS-1:0] mm_y_i,
    input  logic             mm_done_p_i,
    output logic [NBITS-1:0] y_o,
    output logic             busy_o,
    output logic             done_irq_p_o
);

    localparam int              IW        = (EBITS > 1) ? $clog2(EBITS) : 1;
    localparam logic [IW-1:0]   C_IDX_TOP = IW'(EBITS - 1);
    localparam logic [IW-1:0]   C_IDX_ONE = IW'(1);
    localparam logic [NBITS-1:0] C_ONE    = {{(NBITS-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        TO_MONT   = 3'd1,
        SQR       = 3'd2,
        MUL       = 3'd3,
        FROM_MONT = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic             en_q, en_d;
    logic             irq_q, irq_d;
    logic [NBITS-1:0] a_q, a_d;
    logic [NBITS-1:0] r2_q, r2_d;
    logic [NBITS-1:0] m_q, m_d;
    logic [NBITS-1:0] minv_q, minv_d;
    logic [EBITS-1:0] e_q, e_d;
    logic [NBITS-1:0] acc_q, acc_d;
    logic [NBITS-1:0] x_q, x_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [NBITS-1:0] y_q, y_d;
    logic             w_take;

    // A completion pulse only counts while an operation is outstanding; the
    // launch cycle itself is excluded so a stale pulse cannot end a new op.
    assign w_take = mm_done_p_i && !en_q && (state_q != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            en_q    <= 1'b0;
            irq_q   <= 1'b0;
            a_q     <= '0;
            r2_q    <= '0;
            m_q     <= '0;
            minv_q  <= '0;
            e_q     <= '0;
            acc_q   <= '0;
            x_q     <= '0;
            idx_q   <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            irq_q   <= irq_d;
            a_q     <= a_d;
            r2_q    <= r2_d;
            m_q     <= m_d;
            minv_q  <= minv_d;
            e_q     <= e_d;
            acc_q   <= acc_d;
            x_q     <= x_d;
            idx_q   <= idx_d;
            y_q     <= y_d;
        end
    end

    always_comb begin
        state_d = state_q;
        en_d    = 1'b0;
        irq_d   = 1'b0;
        a_d     = a_q;
        r2_d    = r2_q;
        m_d     = m_q;
        minv_d  = minv_q;
        e_d     = e_q;
        acc_d   = acc_q;
        x_d     = x_q;
        idx_d   = idx_q;
        y_d     = y_q;
        mm_a_o  = '0;
        mm_b_o  = '0;

        case (state_q)
            IDLE: begin
                if (start_p_i) begin
                    a_d     = a_i;
                    r2_d    = r2_red_i;
                    m_d     = m_i;
                    minv_d  = m_inv_i;
                    e_d     = e_i;
                    // acc starts as the Montgomery form of 1 (R mod m)
                    acc_d   = r_red_i;
                    idx_d   = C_IDX_TOP;
                    state_d = TO_MONT;
                    en_d    = 1'b1;
                end
            end
            TO_MONT: begin
                mm_a_o = a_q;
                mm_b_o = r2_q;
                if (w_take) begin
                    x_d     = mm_y_i;
                    state_d = SQR;
                    en_d    = 1'b1;
                end
            end
            SQR: begin
                mm_a_o = acc_q;
                mm_b_o = acc_q;
                if (w_take) begin
                    acc_d = mm_y_i;
                    en_d  = 1'b1;
                    if (e_q[idx_q]) begin
                        state_d = MUL;
                    end else if (idx_q != '0) begin
                        idx_d = idx_q - C_IDX_ONE;
                    end else begin
                        state_d = FROM_MONT;
                    end
                end
            end
            MUL: begin
                mm_a_o = acc_q;
                mm_b_o = x_q;
                if (w_take) begin
                    acc_d = mm_y_i;
                    en_d  = 1'b1;
                    if (idx_q != '0) begin
                        idx_d   = idx_q - C_IDX_ONE;
                        state_d = SQR;
                    end else begin
                        state_d = FROM_MONT;
                    end
                end
            end
            FROM_MONT: begin
                // Multiplying by plain 1 strips the R factor
                mm_a_o = acc_q;
                mm_b_o = C_ONE;
                if (w_take) begin
                    y_d     = mm_y_i;
                    irq_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign mm_enable_p_o = en_q;
    assign mm_m_o        = m_q;
    assign mm_m_inv_o    = minv_q;
    assign y_o           = y_q;
    assign busy_o        = (state_q != IDLE);
    assign done_irq_p_o  = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_mont_modexp_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mont_modexp_ctrl
// Description : Self-checking bench for mont_modexp_ctrl. A behavioural
//               Montgomery multiplier answers each launch after a fixed or
//               random latency; results are compared with a plain modular
//               power model and launch/completion timing is checked.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mont_modexp_ctrl;

    localparam int NB = 16;
    localparam int EB = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_p = 1'b0;
    logic [NB-1:0] a = '0, m = '0, r_red = '0, r2_red = '0, m_inv = '0;
    logic [EB-1:0] e = '0;
    logic [NB-1:0] mm_y = '0;
    logic          mm_done_p = 1'b0;

    logic [NB-1:0] mm_a_o, mm_b_o, mm_m_o, mm_m_inv_o, y_o;
    logic          mm_enable_p_o, busy_o, done_irq_p_o;

    mont_modexp_ctrl #(.NBITS(NB), .EBITS(EB)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_p_i    (start_p),
        .a_i          (a),
        .m_i          (m),
        .r_red_i      (r_red),
        .r2_red_i     (r2_red),
        .m_inv_i      (m_inv),
        .e_i          (e),
        .mm_a_o       (mm_a_o),
        .mm_b_o       (mm_b_o),
        .mm_m_o       (mm_m_o),
        .mm_m_inv_o   (mm_m_inv_o),
        .mm_enable_p_o(mm_enable_p_o),
        .mm_y_i       (mm_y),
        .mm_done_p_i  (mm_done_p),
        .y_o          (y_o),
        .busy_o       (busy_o),
        .done_irq_p_o (done_irq_p_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- environment state shared with the multiplier model
    int            lat_fixed = 5;   // 0 selects a random latency of 1..20
    int            pulses    = 0;
    int            irqs      = 0;
    int            ref_cyc   = 0;   // cycle of last start or last completion
    bit            aborted   = 1'b0;
    longint        rinv      = 1;
    logic [NB-1:0] exp_m     = '0;
    logic [NB-1:0] exp_minv  = '0;

    function automatic logic [NB-1:0] mont(input logic [NB-1:0] x, input logic [NB-1:0] z);
        longint mm = longint'(exp_m);
        longint p  = ((longint'(x) % mm) * (longint'(z) % mm)) % mm;
        return NB'((p * rinv) % mm);
    endfunction

    function automatic logic [NB-1:0] ref_pow(input logic [NB-1:0] ta, input int te, input logic [NB-1:0] tm);
        longint mm = longint'(tm);
        longint r  = longint'(1) % mm;
        longint b  = longint'(ta) % mm;
        for (int i = 0; i < te; i++) r = (r * b) % mm;
        return NB'(r);
    endfunction

    // Behavioural Montgomery multiplier: result = x*z*R^-1 mod m, R = 2^NB
    initial begin : g_mult
        bit            pending = 1'b0;
        int            cnt = 0;
        logic [NB-1:0] cap_a = '0, cap_b = '0, res = '0;
        forever begin
            @(posedge clk); #1;
            mm_done_p = 1'b0;
            if (done_irq_p_o) irqs++;
            if (pending) begin
                if (cnt == 0) begin
                    if (!aborted) begin
                        chk("mm_a_stable", mm_a_o, cap_a);
                        chk("mm_b_stable", mm_b_o, cap_b);
                    end
                    mm_y      = res;
                    mm_done_p = 1'b1;
                    pending   = 1'b0;
                    ref_cyc   = cyc;
                end else begin
                    cnt--;
                end
            end
            if (mm_enable_p_o) begin
                pulses++;
                chk("en_gap", cyc - ref_cyc, 1);
                chk("mm_m", mm_m_o, exp_m);
                chk("mm_m_inv", mm_m_inv_o, exp_minv);
                cap_a   = mm_a_o;
                cap_b   = mm_b_o;
                res     = mont(cap_a, cap_b);
                pending = 1'b1;
                cnt     = ((lat_fixed > 0) ? lat_fixed : int'($urandom_range(20, 1))) - 1;
            end
        end
    end

    task automatic setup_inputs(input logic [NB-1:0] ta, input logic [EB-1:0] te, input logic [NB-1:0] tm);
        longint        mm = longint'(tm);
        longint        r  = 65536 % mm;
        logic [NB-1:0] inv = tm;
        repeat (4) inv = inv * (16'd2 - tm * inv);
        a        = ta;
        e        = te;
        m        = tm;
        r_red    = NB'(r);
        r2_red   = NB'((r * r) % mm);
        m_inv    = 16'd0 - inv;
        exp_m    = tm;
        exp_minv = 16'd0 - inv;
        rinv     = 1;
        for (longint k = 1; k < mm; k++) begin
            if ((r * k) % mm == 1) begin
                rinv = k;
                break;
            end
        end
    endtask

    // Runs one exponentiation from a posedge+1 time point and checks it.
    task automatic run_op(input string nm, input logic [NB-1:0] ta, input logic [EB-1:0] te,
                          input logic [NB-1:0] tm, input logic [NB-1:0] ey, input int ep,
                          input bit mid_start);
        bit got = 1'b0;
        setup_inputs(ta, te, tm);
        start_p = 1'b1;
        ref_cyc = cyc;
        pulses  = 0;
        irqs    = 0;
        aborted = 1'b0;
        @(posedge clk); #1;
        start_p = 1'b0;
        chk({nm, "_busy_start"}, busy_o, 1);
        for (int k = 0; k < 2000 && !got; k++) begin
            if (mid_start && k == 12) begin
                // a different request that must be ignored while busy
                a       = 16'd7;
                e       = 4'h0;
                m       = 16'd11;
                r_red   = 16'd9;
                r2_red  = 16'd4;
                m_inv   = 16'h1234;
                start_p = 1'b1;
            end else begin
                start_p = 1'b0;
            end
            @(posedge clk); #1;
            if (done_irq_p_o) got = 1'b1;
        end
        start_p = 1'b0;
        if (!got) begin
            chk({nm, "_timeout"}, 0, 1);
        end else begin
            chk({nm, "_busy_at_irq"}, busy_o, 0);
            chk({nm, "_y"}, y_o, ey);
            chk({nm, "_pulses"}, pulses, ep);
            chk({nm, "_irq_delay"}, cyc - ref_cyc, 1);
            repeat (3) begin
                @(posedge clk); #1;
            end
            chk({nm, "_irq_count"}, irqs, 1);
            chk({nm, "_y_hold"}, y_o, ey);
        end
    endtask

    typedef struct {
        logic [NB-1:0] a;
        logic [EB-1:0] e;
        logic [NB-1:0] m;
        logic [NB-1:0] y;
        int            pulses;
    } vec_t;

    vec_t tbl[8];

    initial begin : g_main
        bit seen;
        tbl[0] = '{16'd4,  4'hD, 16'd13, 16'd4, 9};
        tbl[1] = '{16'd4,  4'h0, 16'd13, 16'd1, 6};
        tbl[2] = '{16'd2,  4'hF, 16'd13, 16'd8, 10};
        tbl[3] = '{16'd3,  4'h5, 16'd13, 16'd9, 8};
        tbl[4] = '{16'd7,  4'h2, 16'd11, 16'd5, 7};
        tbl[5] = '{16'd20, 4'h3, 16'd7,  16'd6, 8};
        tbl[6] = '{16'd0,  4'h8, 16'd13, 16'd0, 7};
        tbl[7] = '{16'd5,  4'h1, 16'd13, 16'd5, 7};

        // ---- reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy_o, 0);
        chk("rst_y", y_o, 0);
        chk("rst_irq", done_irq_p_o, 0);
        chk("rst_en", mm_enable_p_o, 0);
        chk("rst_mm_a", mm_a_o, 0);
        chk("rst_mm_b", mm_b_o, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // ---- directed table, fixed latency 5
        lat_fixed = 5;
        for (int i = 0; i < 8; i++)
            run_op($sformatf("tbl%0d", i), tbl[i].a, tbl[i].e, tbl[i].m, tbl[i].y, tbl[i].pulses, 1'b0);

        // ---- start reasserted mid-run with different operands is ignored
        run_op("midstart", 16'd2, 4'hF, 16'd13, 16'd8, 10, 1'b1);

        // ---- reset during the third SQR (e=0: launches TO_MONT,SQR,SQR,SQR)
        setup_inputs(16'd4, 4'h0, 16'd13);
        start_p = 1'b1;
        ref_cyc = cyc;
        pulses  = 0;
        aborted = 1'b0;
        @(posedge clk); #1;
        start_p = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(posedge clk); #1;
            if (pulses >= 4) seen = 1'b1;
        end
        chk("abort_reach_sqr3", seen, 1);
        aborted = 1'b1;
        rst_n   = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("abort_busy", busy_o, 0);
        chk("abort_en", mm_enable_p_o, 0);
        chk("abort_y", y_o, 0);
        chk("abort_mm_a", mm_a_o, 0);
        irqs = 0;
        repeat (30) begin
            @(posedge clk); #1;
        end
        chk("abort_no_irq", irqs, 0);
        chk("abort_idle", busy_o, 0);
        run_op("after_abort", 16'd4, 4'hD, 16'd13, 16'd4, 9, 1'b0);

        // ---- random operands and random multiplier latency
        lat_fixed = 0;
        for (int i = 0; i < 20; i++) begin
            logic [NB-1:0] ra, rm;
            logic [EB-1:0] re;
            rm = 16'($urandom_range(65535, 3)) | 16'd1;
            ra = 16'($urandom);
            re = 4'($urandom_range(15, 0));
            run_op($sformatf("rand%0d", i), ra, re, rm, ref_pow(ra, int'(re), rm),
                   2 + EB + $countones(re), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin : g_watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
